seletor_codigo: RTL and testbench
=================================

SELETOR_CODIGO -- requirements
Module: seletor_codigo

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 4, giving the number of consecutive synchronized samples a button must hold before a level change is accepted.
REQ-002 The module SHALL have parameter RESET_CODE, default 5'd0, giving the code loaded at reset.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; every flop SHALL be rising-edge triggered.
REQ-004 The module SHALL have port rst, input, 1 bit, asynchronous, active-high reset.
REQ-005 The module SHALL have port btn_up, input, 1 bit, raw asynchronous increment button, active-high.
REQ-006 The module SHALL have port btn_down, input, 1 bit, raw asynchronous decrement button, active-high.
REQ-007 The module SHALL have port btn_load, input, 1 bit, raw asynchronous load button, active-high.
REQ-008 The module SHALL have port sw, input, 5 bits, switch value loaded on a load event; sw[4] is the MSB.
REQ-009 The module SHALL have ports i1, i2, i3, i4, i5, outputs, 1 bit each, the registered code driving the decoder input; i1 is the MSB (weight 16) and i5 the LSB.
REQ-010 The module SHALL have port changed, output, 1 bit, a one-cycle pulse asserted in the cycle the code takes a new value.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Each synchronized button SHALL drive a debounce FSM with states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE.
REQ-013 From IDLE, a sample of 1 SHALL move the FSM to WAIT_PRESS and clear its counter.
REQ-014 In WAIT_PRESS, a sample of 0 SHALL return the FSM to IDLE.
REQ-015 In WAIT_PRESS, DEB_CYCLES consecutive samples of 1 SHALL move the FSM to PRESSED and emit a one-cycle press pulse.
REQ-016 From PRESSED, a sample of 0 SHALL move the FSM to WAIT_RELEASE and clear its counter.
REQ-017 In WAIT_RELEASE, a sample of 1 SHALL return the FSM to PRESSED.
REQ-018 In WAIT_RELEASE, DEB_CYCLES consecutive samples of 0 SHALL return the FSM to IDLE.
REQ-019 Exactly one press pulse SHALL be emitted per accepted press, however long the button is held.
REQ-020 The code register SHALL update on the clock edge after a press pulse.
REQ-021 Latency from a clean raw rising edge to the new code on i1..i5 SHALL be 2 + DEB_CYCLES + 1 clocks.
REQ-022 Same-cycle pulse priority SHALL be load, then up, then down.
REQ-023 Simultaneous up and down pulses without load SHALL leave the code unchanged and SHALL NOT assert changed.
REQ-024 Up SHALL add 1 modulo 32, so 31 wraps to 0.
REQ-025 Down SHALL subtract 1 modulo 32, so 0 wraps to 31.
REQ-026 Load SHALL copy sw, sampled in the cycle of the load pulse, into the code.
REQ-027 changed SHALL assert exactly when the new code differs from the old code; a load of an identical value SHALL NOT assert it.
REQ-028 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-029 While rst is high, the code SHALL be RESET_CODE, so i1..i5 = 00000 by default.
REQ-030 While rst is high, changed SHALL be 0, all FSMs SHALL be in IDLE, and all counters and synchronizer flops SHALL be 0.
REQ-031 A reset mid-debounce SHALL discard the pending press; a button still held after reset SHALL be re-qualified from IDLE and SHALL produce one pulse.

Structure
REQ-032 DEB_CYCLES, the code width (5) and the debounce state encodings SHALL live in the shared package/header used by the display blocks.
REQ-033 The synchronizer and debounce FSM SHALL be one sub-module, debouncer, instantiated three times; the counter, priority and output logic SHALL remain in seletor_codigo.

Verification
REQ-034 Reset: assert rst asynchronously mid-cycle -> i1..i5 = 00000 and changed = 0 immediately.
REQ-035 Up and wrap: 32 clean btn_up presses from 0 -> code 1, 2, ..., 31, 0; changed pulses 32 times; each update arrives 7 clocks after the raw edge with DEB_CYCLES = 4.
REQ-036 Bounce: btn_up toggling 1,0,1,0 at 1-cycle intervals, then held high for 10 cycles -> exactly one increment.
REQ-037 Priority: sw = 10110 with load, up and down pressed in the same cycle -> code 10110; then up and down together -> no change and no changed pulse.
REQ-038 Down wrap: code 00000, one btn_down press -> 11111.
REQ-039 Reset mid-press: rst pulse while btn_up is in WAIT_PRESS, button held afterwards -> exactly one increment after release of rst.

Source files
------------

// File: rtl/seletor_codigo_pkg.sv
// Shared constants and types for the code selector and the display blocks.
// Holds the debounce length, code width and debounce state encodings.
package seletor_codigo_pkg;

    localparam int DEB_CYCLES = 4;
    localparam int CODE_W     = 5;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_PRESS   = 2'b01,
        PRESSED      = 2'b10,
        WAIT_RELEASE = 2'b11
    } deb_state_t;

    typedef struct packed {
        logic load;
        logic up;
        logic down;
    } press_t;

    // Load wins; up and down together cancel out.
    function automatic code_t next_code(
        input code_t  cur,
        input press_t p,
        input code_t  sw
    );
        code_t res;
        res = cur;
        if (p.load) begin
            res = sw;
        end else if (p.up && !p.down) begin
            res = cur + code_t'(1);
        end else if (p.down && !p.up) begin
            res = cur - code_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/seletor_codigo_debouncer.sv
// Two-flop synchronizer followed by a four-state debounce FSM.
// Emits a single registered press pulse per accepted press.
module debouncer
    import seletor_codigo_pkg::*;
#(
    parameter int DEB_CYCLES = seletor_codigo_pkg::DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam bit ONE_SHOT = (DEB_CYCLES <= 1);
    localparam int CW       = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int LAST     = (DEB_CYCLES > 2) ? DEB_CYCLES - 2 : 0;

    logic          s1;
    logic          s2;
    deb_state_t    state;
    deb_state_t    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          press_n;
    logic          hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            press <= press_n;
        end
    end

    // The sample that leaves IDLE/PRESSED is the first of the run.
    assign hit = ONE_SHOT || (cnt == CW'(LAST));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (s2) begin
                    cnt_n   = '0;
                    state_n = ONE_SHOT ? PRESSED : WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!s2) begin
                    state_n = IDLE;
                end else if (hit) begin
                    state_n = PRESSED;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    cnt_n   = '0;
                    state_n = ONE_SHOT ? IDLE : WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (s2) begin
                    state_n = PRESSED;
                end else if (hit) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        press_n = 1'b0;
        unique case (1'b1)
            (state == WAIT_PRESS): press_n = s2 && hit;
            (state == IDLE):       press_n = s2 && ONE_SHOT;
            default:               press_n = 1'b0;
        endcase
    end

endmodule

// File: rtl/seletor_codigo.sv
// Five-bit code selector driven by debounced up/down/load buttons.
// Code and change pulse are registered straight onto the outputs.
module seletor_codigo
    import seletor_codigo_pkg::*;
#(
    parameter int          DEB_CYCLES = seletor_codigo_pkg::DEB_CYCLES,
    parameter logic [4:0]  RESET_CODE = 5'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_load,
    input  logic [4:0] sw,
    output logic       i1,
    output logic       i2,
    output logic       i3,
    output logic       i4,
    output logic       i5,
    output logic       changed
);

    press_t p;
    code_t  code;
    code_t  code_n;

    debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .press (p.up)
    );

    debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_down),
        .press (p.down)
    );

    debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_load),
        .press (p.load)
    );

    always_comb begin
        code_n = next_code(code, p, sw);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code    <= RESET_CODE;
            changed <= 1'b0;
        end else begin
            code    <= code_n;
            changed <= (code_n != code);
        end
    end

    assign {i1, i2, i3, i4, i5} = code;

endmodule

// File: tb/tb_seletor_codigo.sv
// Randomized and directed bench for seletor_codigo against a
// run-length button model and a plain arithmetic code model.
module tb_seletor_codigo;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_load = 1'b0;
    logic [4:0] sw = 5'd0;
    logic       i1, i2, i3, i4, i5;
    logic       changed;
    logic [4:0] dut_code;

    int errors = 0;
    int checks = 0;

    seletor_codigo #(.DEB_CYCLES(DEB), .RESET_CODE(5'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_load (btn_load),
        .sw       (sw),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .i4       (i4),
        .i5       (i5),
        .changed  (changed)
    );

    assign dut_code = {i1, i2, i3, i4, i5};

    always #5 clk = ~clk;

    // Model: a press/release is accepted once the last DEB samples seen
    // after the two-stage synchronizer all disagree with the held level.
    // Index 0 = down, 1 = up, 2 = load.
    logic [4:0]     m_code;
    logic           m_chg;
    logic [2:0]     m_p;
    logic [2:0]     m_d1;
    logic [2:0]     m_d2;
    logic [2:0]     m_lvl;
    logic [DEB-1:0] m_hist [3];
    logic [2:0]     m_raw;
    logic [4:0]     m_nc;
    logic           m_smp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_code = 5'd0;
            m_chg  = 1'b0;
            m_p    = 3'b0;
            m_d1   = 3'b0;
            m_d2   = 3'b0;
            m_lvl  = 3'b0;
            for (int b = 0; b < 3; b++) m_hist[b] = '0;
        end else begin
            m_nc = m_code;
            if (m_p[2]) m_nc = sw;
            else if (m_p[1] && !m_p[0]) m_nc = m_code + 5'd1;
            else if (m_p[0] && !m_p[1]) m_nc = m_code - 5'd1;
            m_chg  = (m_nc != m_code);
            m_code = m_nc;
            m_raw  = {btn_load, btn_up, btn_down};
            for (int b = 0; b < 3; b++) begin
                m_smp     = m_d2[b];
                m_d2[b]   = m_d1[b];
                m_d1[b]   = m_raw[b];
                m_hist[b] = {m_hist[b][DEB-2:0], m_smp};
                m_p[b]    = 1'b0;
                if (m_hist[b] == {DEB{~m_lvl[b]}}) begin
                    m_lvl[b] = ~m_lvl[b];
                    m_p[b]   = m_lvl[b];
                end
            end
        end
    end

    task automatic run(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dut_code !== 5'd0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: code=%b chg=%b want 00000/0", dut_code, changed);
        end
        rst = 1'b0;
        sw = 5'b01101;
        btn_load = 1'b1;
        run(12);
        btn_load = 1'b0;
        run(10);
        checks++;
        if (dut_code !== 5'b01101) begin
            errors++;
            $display("FAIL reset_preload: code=%b want 01101", dut_code);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dut_code !== 5'd0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: code=%b chg=%b want 00000/0", dut_code, changed);
        end
        @(negedge clk);
        rst = 1'b0;
        run(2);
    endtask

    task automatic test_up_wrap;
        int n;
        int pulses;
        pulses = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            btn_up = 1'b1;
            n = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                #1;
                n++;
                if (changed) break;
            end
            if (changed) pulses++;
            checks++;
            if (n !== 2 + DEB + 1) begin
                errors++;
                $display("FAIL up_latency: press %0d took %0d clocks want %0d", k, n, 2 + DEB + 1);
            end
            checks++;
            if (dut_code !== 5'(k % 32) || dut_code !== m_code) begin
                errors++;
                $display("FAIL up_code: press %0d code=%0d want %0d", k, dut_code, k % 32);
            end
            @(negedge clk);
            btn_up = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                #1;
                if (changed) pulses++;
            end
        end
        checks++;
        if (pulses !== 32) begin
            errors++;
            $display("FAIL up_pulses: got %0d changed pulses want 32", pulses);
        end
    endtask

    task automatic test_bounce;
        logic [4:0] c0;
        logic       pat [14];
        int         pulses;
        c0 = dut_code;
        pulses = 0;
        for (int k = 0; k < 14; k++) pat[k] = (k < 4) ? ((k % 2) == 0) : 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            btn_up = (k < 14) ? pat[k] : 1'b0;
            @(posedge clk);
            #1;
            if (changed) pulses++;
            checks++;
            if (dut_code !== m_code || changed !== m_chg) begin
                errors++;
                $display("FAIL bounce_model: cyc %0d code=%b chg=%b want %b/%b", k, dut_code, changed, m_code, m_chg);
            end
        end
        checks++;
        if (pulses !== 1 || dut_code !== c0 + 5'd1) begin
            errors++;
            $display("FAIL bounce_once: pulses=%0d code=%0d want 1/%0d", pulses, dut_code, c0 + 5'd1);
        end
    endtask

    task automatic test_priority;
        int pulses;
        sw = 5'b10110;
        @(negedge clk);
        {btn_load, btn_up, btn_down} = 3'b111;
        run(10);
        {btn_load, btn_up, btn_down} = 3'b000;
        run(10);
        checks++;
        if (dut_code !== 5'b10110) begin
            errors++;
            $display("FAIL prio_load: code=%b want 10110", dut_code);
        end
        pulses = 0;
        sw = 5'b00011;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            {btn_up, btn_down} = (k < 10) ? 2'b11 : 2'b00;
            @(posedge clk);
            #1;
            if (changed) pulses++;
        end
        checks++;
        if (pulses !== 0 || dut_code !== 5'b10110) begin
            errors++;
            $display("FAIL prio_updown: pulses=%0d code=%b want 0/10110", pulses, dut_code);
        end
    endtask

    task automatic test_down_wrap;
        sw = 5'b00000;
        @(negedge clk);
        btn_load = 1'b1;
        run(10);
        btn_load = 1'b0;
        run(10);
        checks++;
        if (dut_code !== 5'd0) begin
            errors++;
            $display("FAIL down_preload: code=%b want 00000", dut_code);
        end
        btn_down = 1'b1;
        run(10);
        btn_down = 1'b0;
        run(10);
        checks++;
        if (dut_code !== 5'b11111) begin
            errors++;
            $display("FAIL down_wrap: code=%b want 11111", dut_code);
        end
    endtask

    task automatic test_reset_mid_press;
        int pulses;
        pulses = 0;
        @(negedge clk);
        btn_up = 1'b1;
        run(4);
        rst = 1'b1;
        #1;
        checks++;
        if (dut_code !== 5'd0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: code=%b chg=%b want 00000/0", dut_code, changed);
        end
        run(2);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (changed) pulses++;
        end
        checks++;
        if (pulses !== 1 || dut_code !== 5'd1) begin
            errors++;
            $display("FAIL midrst_once: pulses=%0d code=%0d want 1/1", pulses, dut_code);
        end
        @(negedge clk);
        btn_up = 1'b0;
        run(10);
    endtask

    task automatic test_random;
        int hold [3];
        int bad;
        bad = 0;
        for (int b = 0; b < 3; b++) hold[b] = 1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    hold[b] = $urandom_range(1, 12);
                    unique case (b)
                        0: btn_down = ~btn_down;
                        1: btn_up   = ~btn_up;
                        default: btn_load = ~btn_load;
                    endcase
                end
            end
            sw = 5'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (dut_code !== m_code || changed !== m_chg) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_model: cyc %0d code=%b chg=%b want %b/%b", k, dut_code, changed, m_code, m_chg);
            end
        end
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_bounce;
        test_priority;
        test_down_wrap;
        test_reset_mid_press;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
